// File: rtl/mdio_master_if.sv
// mdio_master_if: request/response bundle between the register front end and
// the MDIO frame engine.
//   start     request pulse (ignored while busy)
//   op_read   1 = read frame, 0 = write frame
//   phy_addr  PHYAD, reg_addr REGAD, wdata write payload
//   rdata     read result, rd_err missing read turnaround acknowledge
//   busy      transaction in progress, done one-clk completion pulse
// modport master: request side (front end); modport slave: the frame engine.
interface mdio_master_if;
  logic        start;
  logic        op_read;
  logic [4:0]  phy_addr;
  logic [4:0]  reg_addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        rd_err;
  logic        busy;
  logic        done;

  modport master (
    output start, op_read, phy_addr, reg_addr, wdata,
    input  rdata, rd_err, busy, done
  );

  modport slave (
    input  start, op_read, phy_addr, reg_addr, wdata,
    output rdata, rd_err, busy, done
  );
endinterface

// File: rtl/mdio_master.sv
// mdio_master: IEEE 802.3 Clause 22 MDIO management-frame initiator.
// Generates MDC (f_clk / (2*CLK_DIV)) and serialises 64-bit read/write frames:
// 32-bit preamble, ST, OP, PHYAD, REGAD, TA, 16 data bits, MSB first.
// The MDIO line changes only at MDC fall events; mdio_i is sampled in the clk
// cycle in which MDC is about to rise.
// Ports:
//   clk      system clock
//   rst      synchronous, active-low reset
//   req      mdio_master_if.slave request/response bundle
//   mdc      management clock, free running after reset
//   mdio_o   MDIO drive value, mdio_oe 1 = master drives MDIO
//   mdio_i   MDIO pad input (board pull-up)
// Optional build macro MDIO_RD_ACK_CHECK_EN: sample the second TA bit of read
// frames and flag rd_err when the PHY did not pull it low. Without it rd_err
// is constant 0.
module mdio_master #(
  parameter int unsigned CLK_DIV = 20
) (
  input  logic          clk,
  input  logic          rst,
  mdio_master_if.slave  req,
  output logic          mdc,
  output logic          mdio_o,
  output logic          mdio_oe,
  input  logic          mdio_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_PRE,
    S_HDR,
    S_TA,
    S_DATA
  } state_e;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_e      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic        mdc_q, mdc_d;
  logic        tick, fall_ev, rise_ev;
  logic [5:0]  cnt_q, cnt_d;
  logic        op_q, op_d;
  logic [4:0]  phy_q, phy_d;
  logic [4:0]  reg_q, reg_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] tx_q, tx_d;
  logic [15:0] rx_q, rx_d;
  logic [15:0] rdata_q, rdata_d;
  logic        mdio_o_q, mdio_o_d;
  logic        mdio_oe_q, mdio_oe_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [13:0] hdr;
`ifdef MDIO_RD_ACK_CHECK_EN
  logic        ack_q, ack_d;
  logic        rd_err_q, rd_err_d;
`endif

  // MDC divider: one tick per half period, the tick toggles MDC.
  always_comb begin
    tick    = (div_q == DIV_LAST);
    div_d   = tick ? '0 : div_q + 8'd1;
    mdc_d   = tick ? ~mdc_q : mdc_q;
    fall_ev = tick & mdc_q;
    rise_ev = tick & ~mdc_q;
  end

  assign hdr = {2'b01, (op_q ? 2'b10 : 2'b01), phy_q, reg_q};

  // Each fall event loads the value of the bit that starts there, so the
  // drive decisions below always describe the next bit on the line.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    phy_d     = phy_q;
    reg_d     = reg_q;
    wdata_d   = wdata_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rdata_d   = rdata_q;
    mdio_o_d  = mdio_o_q;
    mdio_oe_d = mdio_oe_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
`ifdef MDIO_RD_ACK_CHECK_EN
    ack_d     = ack_q;
    rd_err_d  = rd_err_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (req.start) begin
          op_d    = req.op_read;
          phy_d   = req.phy_addr;
          reg_d   = req.reg_addr;
          wdata_d = req.wdata;
          busy_d  = 1'b1;
          state_d = S_WAIT;
`ifdef MDIO_RD_ACK_CHECK_EN
          rd_err_d = 1'b0;
`endif
        end
      end

      S_WAIT: begin
        if (fall_ev) begin
          state_d   = S_PRE;
          cnt_d     = '0;
          mdio_oe_d = 1'b1;
          mdio_o_d  = 1'b1;
        end
      end

      S_PRE: begin
        if (fall_ev) begin
          if (cnt_q == 6'd31) begin
            state_d  = S_HDR;
            cnt_d    = '0;
            mdio_o_d = hdr[13];
            tx_d     = {hdr[12:0], 3'b000};
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end

      S_HDR: begin
        if (fall_ev) begin
          if (cnt_q == 6'd13) begin
            state_d   = S_TA;
            cnt_d     = '0;
            mdio_o_d  = 1'b1;
            mdio_oe_d = ~op_q;
          end else begin
            cnt_d    = cnt_q + 6'd1;
            mdio_o_d = tx_q[15];
            tx_d     = {tx_q[14:0], 1'b0};
          end
        end
      end

      S_TA: begin
`ifdef MDIO_RD_ACK_CHECK_EN
        if (rise_ev && op_q && (cnt_q == 6'd1)) begin
          ack_d = mdio_i;
        end
`endif
        if (fall_ev) begin
          if (cnt_q == 6'd0) begin
            cnt_d = 6'd1;
            if (!op_q) begin
              mdio_o_d = 1'b0;
            end
          end else begin
            state_d = S_DATA;
            cnt_d   = '0;
            if (!op_q) begin
              mdio_o_d = wdata_q[15];
              tx_d     = {wdata_q[14:0], 1'b0};
            end
          end
        end
      end

      S_DATA: begin
        if (rise_ev && op_q) begin
          rx_d = {rx_q[14:0], mdio_i};
        end
        if (fall_ev) begin
          if (cnt_q == 6'd15) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            mdio_oe_d = 1'b0;
            mdio_o_d  = 1'b1;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            if (op_q) begin
              rdata_d = rx_q;
`ifdef MDIO_RD_ACK_CHECK_EN
              rd_err_d = ack_q;
`endif
            end
          end else begin
            cnt_d = cnt_q + 6'd1;
            if (!op_q) begin
              mdio_o_d = tx_q[15];
              tx_d     = {tx_q[14:0], 1'b0};
            end
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      mdc_q     <= 1'b0;
      cnt_q     <= '0;
      op_q      <= 1'b0;
      phy_q     <= '0;
      reg_q     <= '0;
      wdata_q   <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      rdata_q   <= '0;
      mdio_o_q  <= 1'b1;
      mdio_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef MDIO_RD_ACK_CHECK_EN
      ack_q     <= 1'b1;
      rd_err_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      mdc_q     <= mdc_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      phy_q     <= phy_d;
      reg_q     <= reg_d;
      wdata_q   <= wdata_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rdata_q   <= rdata_d;
      mdio_o_q  <= mdio_o_d;
      mdio_oe_q <= mdio_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef MDIO_RD_ACK_CHECK_EN
      ack_q     <= ack_d;
      rd_err_q  <= rd_err_d;
`endif
    end
  end

  assign mdc        = mdc_q;
  assign mdio_o     = mdio_o_q;
  assign mdio_oe    = mdio_oe_q;
  assign req.rdata  = rdata_q;
  assign req.busy   = busy_q;
  assign req.done   = done_q;
`ifdef MDIO_RD_ACK_CHECK_EN
  assign req.rd_err = rd_err_q;
`else
  assign req.rd_err = 1'b0;
`endif

endmodule

// File: tb/tb_mdio_master.sv
// tb_mdio_master: directed bench for mdio_master with CLK_DIV=4 and a Clause-22
// PHY model at PHYAD 1 (REG1 = 0x7849) sharing a pulled-up MDIO line.
module tb_mdio_master;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic mdc, mdio_o, mdio_oe, mdio_line;
  logic phy_oe, phy_o;

  mdio_master_if bus ();

  mdio_master #(.CLK_DIV(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (bus),
    .mdc     (mdc),
    .mdio_o  (mdio_o),
    .mdio_oe (mdio_oe),
    .mdio_i  (mdio_line)
  );

  always #5 clk = ~clk;

  assign mdio_line = mdio_oe ? mdio_o : (phy_oe ? phy_o : 1'b1);

  // PHY model: hunts for >=32 ones then ST=0, decodes the header, answers
  // reads addressed to PHYAD 1 by driving TA low and the register value.
  int          pb = -1;
  int          ones = 0;
  logic [13:0] fr = '0;
  logic        resp = 1'b0;
  logic        rd_frame = 1'b0;
  logic        oe_viol = 1'b0;
  logic [15:0] pdat = '0;
  logic [15:0] psh = '0;
  logic        nxt_oe = 1'b0;
  logic        nxt_o = 1'b1;
  logic [63:0] line_sh = '1;

  always @(posedge mdc or negedge rst) begin
    if (!rst) begin
      pb       <= -1;
      ones     <= 0;
      fr       <= '0;
      resp     <= 1'b0;
      rd_frame <= 1'b0;
      oe_viol  <= 1'b0;
      psh      <= '0;
      nxt_oe   <= 1'b0;
      nxt_o    <= 1'b1;
      line_sh  <= '1;
    end else begin
      line_sh <= {line_sh[62:0], mdio_line};
      fr      <= {fr[12:0], mdio_line};
      nxt_oe  <= 1'b0;
      nxt_o   <= 1'b1;
      if (pb < 0) begin
        if (mdio_line) begin
          ones <= (ones < 32) ? ones + 1 : ones;
        end else begin
          if (ones >= 32) pb <= 1;
          ones <= 0;
        end
      end else begin
        pb <= (pb == 31) ? -1 : pb + 1;
        if (pb >= 14 && rd_frame && mdio_oe) oe_viol <= 1'b1;
        if (pb == 13) begin
          rd_frame <= (fr[10:9] == 2'b10);
          resp     <= (fr[10:9] == 2'b10) && (fr[8:4] == 5'd1);
          pdat     <= ({fr[3:0], mdio_line} == 5'd1) ? 16'h7849 : 16'h0000;
        end
        if (pb == 14 && resp) begin
          nxt_oe <= 1'b1;
          nxt_o  <= 1'b0;
        end
        if (pb == 15 && resp) begin
          nxt_oe <= 1'b1;
          nxt_o  <= pdat[15];
          psh    <= {pdat[14:0], 1'b0};
        end
        if (pb >= 16 && pb <= 30 && resp) begin
          nxt_oe <= 1'b1;
          nxt_o  <= psh[15];
          psh    <= {psh[14:0], 1'b0};
        end
        if (pb == 31) begin
          resp     <= 1'b0;
          rd_frame <= 1'b0;
          ones     <= 0;
        end
      end
    end
  end

  always @(negedge mdc or negedge rst) begin
    if (!rst) begin
      phy_oe <= 1'b0;
      phy_o  <= 1'b1;
    end else begin
      phy_oe <= nxt_oe;
      phy_o  <= nxt_o;
    end
  end

  // Cycle monitor: values seen at posedge k are stamped k-1, i.e. the edge
  // that produced them.
  int   cyc = 0;
  int   oe_rise_cyc = 0;
  int   done_cnt = 0;
  logic oe_prev = 1'b0;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    oe_prev <= mdio_oe;
    if (mdio_oe && !oe_prev) oe_rise_cyc <= cyc;
    if (bus.done) done_cnt <= done_cnt + 1;
  end

  int checks = 0;
  int failures = 0;
  int t_done = 0;
  int d1 = 0;
  int dc0 = 0;
  logic exp_err;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic rd, input logic [4:0] pa, input logic [4:0] ra,
                       input logic [15:0] wd);
    bus.start    = 1'b1;
    bus.op_read  = rd;
    bus.phy_addr = pa;
    bus.reg_addr = ra;
    bus.wdata    = wd;
    @(negedge clk);
    bus.start    = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.done !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    t_done = cyc;
    check({tag, "_done_seen"}, {63'd0, bus.done}, 64'd1);
  endtask

  task automatic wait_oe(input string tag);
    int n;
    n = 0;
    while (mdio_oe !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_oe_seen"}, {63'd0, mdio_oe}, 64'd1);
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.op_read  = 1'b0;
    bus.phy_addr = '0;
    bus.reg_addr = '0;
    bus.wdata    = '0;
`ifdef MDIO_RD_ACK_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_mdc",    {63'd0, mdc},        64'd0);
    check("rst_mdio_o", {63'd0, mdio_o},     64'd1);
    check("rst_oe",     {63'd0, mdio_oe},    64'd0);
    check("rst_busy",   {63'd0, bus.busy},   64'd0);
    check("rst_done",   {63'd0, bus.done},   64'd0);
    check("rst_rdata",  {48'd0, bus.rdata},  64'd0);
    check("rst_rd_err", {63'd0, bus.rd_err}, 64'd0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // Write PHYAD 1 REGAD 0 = 0x1140
    issue(1'b0, 5'd1, 5'd0, 16'h1140);
    check("wr_busy_rise", {63'd0, bus.busy}, 64'd1);
    wait_done("wr");
    check("wr_busy_in_done", {63'd0, bus.busy}, 64'd0);
    check("wr_frame_len", 64'(t_done - oe_rise_cyc), 64'd512);
    check("wr_line", line_sh,
          {32'hFFFF_FFFF, 2'b01, 2'b01, 5'd1, 5'd0, 2'b10, 16'h1140});
    check("wr_rdata_kept", {48'd0, bus.rdata}, 64'd0);
    check("wr_oe_released", {63'd0, mdio_oe}, 64'd0);
    @(negedge clk);
    check("wr_done_one_clk", {63'd0, bus.done}, 64'd0);

    // Read PHYAD 1 REGAD 1
    repeat (3) @(negedge clk);
    issue(1'b1, 5'd1, 5'd1, 16'h0000);
    wait_done("rd1");
    check("rd1_rdata",  {48'd0, bus.rdata},  64'h7849);
    check("rd1_rd_err", {63'd0, bus.rd_err}, 64'd0);
    check("rd1_oe_off", {63'd0, oe_viol},    64'd0);
    check("rd1_frame_len", 64'(t_done - oe_rise_cyc), 64'd512);

    // Read absent PHY 7
    repeat (3) @(negedge clk);
    issue(1'b1, 5'd7, 5'd1, 16'h0000);
    wait_done("rd7");
    check("rd7_rdata",  {48'd0, bus.rdata},  64'hFFFF);
    check("rd7_rd_err", {63'd0, bus.rd_err}, {63'd0, exp_err});

    // start during an active read is ignored
    repeat (3) @(negedge clk);
    dc0 = done_cnt;
    issue(1'b1, 5'd1, 5'd1, 16'h0000);
    wait_oe("ign");
    repeat (80) @(negedge clk);
    issue(1'b0, 5'd1, 5'd0, 16'hABCD);
    wait_done("ign");
    check("ign_rdata", {48'd0, bus.rdata}, 64'h7849);
    repeat (600) @(negedge clk);
    check("ign_single_done", 64'(done_cnt - dc0), 64'd1);
    check("ign_idle", {63'd0, bus.busy}, 64'd0);

    // Reset pulse at header bit 5 of a read
    issue(1'b1, 5'd1, 5'd1, 16'h0000);
    wait_oe("mrst");
    repeat (298) @(negedge clk);
    dc0 = done_cnt;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("mrst_mdc",    {63'd0, mdc},        64'd0);
    check("mrst_mdio_o", {63'd0, mdio_o},     64'd1);
    check("mrst_oe",     {63'd0, mdio_oe},    64'd0);
    check("mrst_busy",   {63'd0, bus.busy},   64'd0);
    check("mrst_done",   {63'd0, bus.done},   64'd0);
    check("mrst_rdata",  {48'd0, bus.rdata},  64'd0);
    check("mrst_rd_err", {63'd0, bus.rd_err}, 64'd0);
    repeat (100) @(negedge clk);
    check("mrst_no_done", 64'(done_cnt - dc0), 64'd0);
    issue(1'b1, 5'd1, 5'd1, 16'h0000);
    wait_done("mrst_rd");
    check("mrst_rd_rdata", {48'd0, bus.rdata}, 64'h7849);

    // Back-to-back reads, second start in the done cycle
    repeat (3) @(negedge clk);
    issue(1'b1, 5'd1, 5'd1, 16'h0000);
    wait_done("b2b1");
    check("b2b1_rdata", {48'd0, bus.rdata}, 64'h7849);
    d1 = t_done;
    issue(1'b1, 5'd1, 5'd1, 16'h0000);
    check("b2b_busy", {63'd0, bus.busy}, 64'd1);
    wait_done("b2b2");
    check("b2b_gap", 64'(oe_rise_cyc - d1), 64'd8);
    check("b2b2_frame_len", 64'(t_done - oe_rise_cyc), 64'd512);
    check("b2b2_rdata", {48'd0, bus.rdata}, 64'h7849);
    check("b2b_oe_off", {63'd0, oe_viol}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
